cla_subtractor_seq: RTL and testbench
=====================================

CLA_SUBTRACTOR_SEQ -- requirements
Module: cla_subtractor_seq

Interface
REQ-001 The module SHALL have exactly one clock and a synchronous, active-high reset.
REQ-002 The module SHALL have a parameter NIB with default 4 and meaning "operand width in 4-bit nibbles"; the width W = 4*NIB, which is 16 by default.
REQ-003 clk  input  1  clock; every register updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active high.
REQ-005 start  input  1  request a new subtraction; sampled only in state IDLE.
REQ-006 a  input  W  minuend, unsigned or two's complement.
REQ-007 b  input  W  subtrahend.
REQ-008 bin  input  1  borrow in.
REQ-009 d  output  W  difference, registered.
REQ-010 bout  output  1  borrow out, registered; 1 exactly when a < b + bin (unsigned).
REQ-011 ovf  output  1  signed overflow, registered.
REQ-012 busy  output  1  high in state RUN.
REQ-013 done  output  1  one-cycle pulse, high in state DONE.

Function
REQ-014 The module SHALL compute a - b - bin as a + ~b + (1 - bin).
- One 4-bit carry-lookahead nibble per cycle.
- Per bit: g = a & ~b, p = a ^ ~b.
- Nibble carries are computed from g/p lookahead, not by rippling through the bits.
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE.
- Reset state: IDLE.
- DONE SHALL always go to IDLE on the next cycle.
REQ-016 IDLE with start=1 at edge E0 SHALL:
- latch a, b and bin into internal registers;
- set the nibble counter to 0 and the carry register to ~bin;
- enter RUN.
IDLE with start=0 SHALL stay in IDLE.
REQ-017 At each RUN edge the module SHALL:
- compute nibble[cnt] from the latched operands and the carry register;
- store the nibble into the internal difference register;
- update the carry register with the nibble carry-out;
- increment cnt.
REQ-018 The RUN edge with cnt = NIB-1 SHALL:
- load d from the internal difference register, including the final nibble;
- load bout = ~(final carry);
- load ovf = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]), using the latched operands;
- enter DONE.
REQ-019 Latency SHALL be fixed:
- done=1 during the cycle following edge E0+NIB (edge E0+4 by default);
- the FSM is in IDLE again after edge E0+NIB+1;
- the next start is accepted no earlier than edge E0+NIB+1.
REQ-020 Start asserted in RUN or DONE SHALL be ignored: no re-latch, no extra done pulse.
REQ-021 Input changes on a, b or bin after E0 SHALL NOT affect the result in progress.
REQ-022 d, bout and ovf SHALL hold their value until the next REQ-018 update; they do not change during RUN.
REQ-023 busy and done SHALL never be high in the same cycle.
REQ-024 Arithmetic SHALL wrap modulo 2^W with no saturation.
- a == b with bin=1 yields all-ones with bout=1.
- a=0, b=all-ones, bin=1 yields d=0 with bout=1.

Reset
REQ-025 rst=1 at any edge SHALL force:
- state to IDLE and cnt to 0;
- the carry register and internal difference register to 0;
- d to 0, bout to 0, ovf to 0;
- busy to 0 and done to 0.
REQ-026 rst asserted mid-RUN SHALL abort the operation; no done pulse follows for the aborted request.
REQ-027 rst has priority over start in the same cycle; that start is not accepted.

Verification
REQ-028 a=0x1234, b=0x0034, bin=0, start pulse at E0 -> busy high for 4 cycles, then done=1 one cycle; d=0x1200, bout=0, ovf=0.
REQ-029 a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, ovf=0.
REQ-030 a=0x8000, b=0x0001, bin=0 -> d=0x7FFF, bout=0, ovf=1.
REQ-031 a=0x0005, b=0x0005, bin=1 -> d=0xFFFF, bout=1, ovf=0.
REQ-032 Start with a=0x00F0, b=0x000F, bin=0; during RUN hold start=1 with a=0xFFFF, b=0 -> exactly one done pulse with d=0x00E1, bout=0; the second request is not accepted.
REQ-033 Start with a=0x1234, b=0x0034, bin=0, then rst=1 at the second RUN edge -> next cycle busy=0, done=0, d=0x0000, bout=0, ovf=0; no done pulse for 6 cycles with start=0; a new start then completes normally with REQ-019 latency.

Source files
------------

// File: rtl/cla_subtractor_seq.sv
// Sequential subtractor: a - b - bin evaluated one 4-bit carry-lookahead nibble per clock.
// Result, borrow-out and signed overflow are registered once the last nibble completes.
module cla_subtractor_seq #(
    parameter int unsigned NIB = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NIB-1:0]  a,
    input  logic [4*NIB-1:0]  b,
    input  logic              bin,
    output logic [4*NIB-1:0]  d,
    output logic              bout,
    output logic              ovf,
    output logic              busy,
    output logic              done
);
    localparam int unsigned W  = 4 * NIB;
    localparam int unsigned CW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic [W-1:0]   a_r, b_r, diff_r, diff_nx;
    logic [3:0]     na, nb, g, p, s;
    logic [4:0]     c;
    logic           last;

    // Subtraction as a + ~b + carry, with carry seeded from ~bin.
    always_comb begin
        na = '0;
        nb = '0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (cnt == CW'(i)) begin
                na = a_r[4*i +: 4];
                nb = ~b_r[4*i +: 4];
            end
        end
        g    = na & nb;
        p    = na ^ nb;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];

        diff_nx = diff_r;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (cnt == CW'(i)) diff_nx[4*i +: 4] = s;
        end
        last = (cnt == CW'(NIB - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            d      <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        cnt   <= '0;
                        carry <= ~bin;
                    end
                end
                RUN: begin
                    diff_r <= diff_nx;
                    carry  <= c[4];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        d    <= diff_nx;
                        bout <= ~c[4];
                        ovf  <= (a_r[W-1] != b_r[W-1]) && (diff_nx[W-1] != a_r[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_subtractor_seq.sv
// Directed self-checking bench for cla_subtractor_seq (default NIB=4, 16-bit operands).
// Expected results are hand-computed constants; outputs are sampled on the falling edge.
module tb_cla_subtractor_seq;
    logic        clk = 1'b0;
    logic        rst, start, bin;
    logic [15:0] a, b, d;
    logic        bout, ovf, busy, done;

    int checks = 0;
    int errors = 0;

    // Last result the bench expects to be held on d/bout/ovf.
    logic [15:0] hold_d    = '0;
    logic        hold_bout = 1'b0;
    logic        hold_ovf  = 1'b0;

    cla_subtractor_seq #(.NIB(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .d(d), .bout(bout), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h0001; bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (d !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: d=%h bout=%b ovf=%b expected 0000 0 0", d, bout, ovf);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: busy=%b expected 0", busy);
        end
        hold_d = '0; hold_bout = 1'b0; hold_ovf = 1'b0;
    endtask

    // One full transaction: latency, hold during RUN, single done pulse, result.
    task automatic test_vector(input string name, input logic [15:0] ta, input logic [15:0] tb_in,
                               input logic tbin, input logic [15:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_in; bin = tbin;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s_run%0d: busy=%b done=%b expected 1 0", name, k, busy, done);
            end
            checks++;
            if (d !== hold_d || bout !== hold_bout || ovf !== hold_ovf) begin
                errors++;
                $display("FAIL %s_hold%0d: d=%h bout=%b ovf=%b expected %h %b %b",
                         name, k, d, bout, ovf, hold_d, hold_bout, hold_ovf);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b expected 1 0", name, done, busy);
        end
        checks++;
        if (d !== ed || bout !== eb || ovf !== eo) begin
            errors++;
            $display("FAIL %s_result: d=%h bout=%b ovf=%b expected %h %b %b", name, d, bout, ovf, ed, eb, eo);
        end
        hold_d = ed; hold_bout = eb; hold_ovf = eo;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_arith();
        test_vector("basic",   16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
        test_vector("under",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        test_vector("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        test_vector("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        test_vector("bin_nib", 16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0, 1'b0);
    endtask

    task automatic test_boundary();
        test_vector("eq_bin",  16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        test_vector("zero_ff", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_start_during_run();
        int pulses = 0;
        @(negedge clk);
        start = 1'b1; a = 16'h00F0; b = 16'h000F; bin = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        start = 1'b0;
        if (done === 1'b1) pulses++;
        checks++;
        if (d !== 16'h00E1 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_result: d=%h bout=%b ovf=%b expected 00e1 0 0", d, bout, ovf);
        end
        hold_d = 16'h00E1; hold_bout = 1'b0; hold_ovf = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_start_reaccept%0d: busy=%b expected 0", k, busy);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL busy_start_pulses: got %0d done pulses expected 1", pulses);
        end
        checks++;
        if (d !== 16'h00E1) begin
            errors++;
            $display("FAIL busy_start_hold: d=%h expected 00e1", d);
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0;
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h0034; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_ctrl: busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (d !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_out: d=%h bout=%b ovf=%b expected 0000 0 0", d, bout, ovf);
        end
        hold_d = '0; hold_bout = 1'b0; hold_ovf = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d busy/done cycles expected 0", pulses);
        end
        test_vector("after_abort", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        test_reset();
        test_arith();
        test_boundary();
        test_start_during_run();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
